// File: rtl/fpu_issue_wb.sv
// fpu_issue_wb: issue/writeback sequencer around the fixed-latency FPU pipes.
// Reserves one completion slot per cycle and queues tagged results for writeback.
module fpu_issue_wb #(
  parameter int WIDTH      = 24,
  parameter int TAG_W      = 5,
  parameter int ADD_LAT    = 3,
  parameter int MUL_LAT    = 2,
  parameter int MISC_LAT   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_opcode,
  input  logic [TAG_W-1:0] in_tag,
  output logic [WIDTH-1:0] fpu_a,
  output logic [WIDTH-1:0] fpu_b,
  output logic [3:0]       fpu_opcode,
  input  logic [WIDTH-1:0] fpu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [WIDTH-1:0] out_result,
  output logic             busy
);

  localparam int MAX_AM  = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam int MAX_LAT = (MAX_AM > MISC_LAT) ? MAX_AM : MISC_LAT;
  localparam int LW      = $clog2(MAX_LAT + 1);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int OW      = AW + 1;
  localparam int CW      = $clog2(MAX_LAT + FIFO_DEPTH + 1) + 1;

  // slot_v[k]: a result lands on fpu_result k cycles from now
  logic [MAX_LAT:0] slot_v;
  logic [TAG_W-1:0] slot_tag [MAX_LAT+1];
  logic [TAG_W-1:0] q_tag [FIFO_DEPTH];
  logic [WIDTH-1:0] q_res [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [OW-1:0]    occ;
  logic [LW-1:0]    in_lat;
  logic [CW-1:0]    inflight;
  logic             is_add;
  logic             is_mul;
  logic             fire;
  logic             push;
  logic             pop;
  logic             credit_ok;

  assign fpu_a      = in_a;
  assign fpu_b      = in_b;
  assign fpu_opcode = in_opcode;

  always_comb begin
    is_add = in_opcode inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd8, 4'd9};
    is_mul = in_opcode == 4'd3;
    in_lat = LW'(MISC_LAT);
    unique case (1'b1)
      is_add:  in_lat = LW'(ADD_LAT);
      is_mul:  in_lat = LW'(MUL_LAT);
      default: in_lat = LW'(MISC_LAT);
    endcase
  end

  always_comb begin
    inflight = '0;
    for (int j = 0; j <= MAX_LAT; j++)
      inflight = inflight + CW'(slot_v[j]);
  end

  // every in-flight op owns a FIFO entry so a push can never overflow
  assign credit_ok = (inflight + CW'(occ)) < CW'(FIFO_DEPTH);
  assign in_ready  = rst_n && !slot_v[in_lat] && credit_ok;
  assign fire      = in_valid && in_ready;
  assign push      = slot_v[0];
  assign out_valid = occ != '0;
  assign pop       = out_valid && out_ready;
  assign out_tag    = out_valid ? q_tag[rd_ptr] : '0;
  assign out_result = out_valid ? q_res[rd_ptr] : '0;
  assign busy       = (|slot_v) || out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_v <= '0;
      for (int j = 0; j <= MAX_LAT; j++)
        slot_tag[j] <= '0;
    end else begin
      slot_v <= {1'b0, slot_v[MAX_LAT:1]};
      for (int j = 0; j < MAX_LAT; j++)
        slot_tag[j] <= slot_tag[j+1];
      slot_tag[MAX_LAT] <= '0;
      if (fire) begin
        slot_v[in_lat - LW'(1)]   <= 1'b1;
        slot_tag[in_lat - LW'(1)] <= in_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        q_tag[i] <= '0;
        q_res[i] <= '0;
      end
    end else begin
      if (push) begin
        q_tag[wr_ptr] <= slot_tag[0];
        q_res[wr_ptr] <= fpu_result;
        wr_ptr        <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      occ <= occ + OW'(push) - OW'(pop);
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && occ == OW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_fpu_issue_wb.sv
// tb_fpu_issue_wb: random and directed bench for fpu_issue_wb.
// FPU stub and scoreboard are driven from a cycle-level reference model.
module tb_fpu_issue_wb;

  localparam int W     = 24;
  localparam int TW    = 5;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [3:0]    in_opcode;
  logic [TW-1:0] in_tag;
  logic [W-1:0]  fpu_a;
  logic [W-1:0]  fpu_b;
  logic [3:0]    fpu_opcode;
  logic [W-1:0]  fpu_result;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_tag;
  logic [W-1:0]  out_result;
  logic          busy;

  always #5 clk = ~clk;

  fpu_issue_wb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_opcode  (in_opcode),
    .in_tag     (in_tag),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_opcode (fpu_opcode),
    .fpu_result (fpu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_tag    (out_tag),
    .out_result (out_result),
    .busy       (busy)
  );

  typedef struct {
    int            due;
    logic [TW-1:0] tag;
    logic [W-1:0]  res;
  } op_t;

  typedef struct {
    logic [TW-1:0] tag;
    logic [W-1:0]  res;
  } wb_t;

  op_t           pend[$];
  wb_t           fifo_q[$];
  logic [TW-1:0] popped[$];
  int            cyc;
  int            n_chk;
  int            n_pass;
  logic          obs_ready;
  logic          obs_ov;
  logic          obs_busy;
  logic          last_fire;
  logic [TW-1:0] obs_tag;
  logic [W-1:0]  obs_res;

  function automatic int lat_of(logic [3:0] op);
    if (op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd8, 4'd9}) return 3;
    if (op == 4'd3) return 2;
    return 1;
  endfunction

  function automatic logic [W-1:0] fpu_model(logic [3:0] op,
                                             logic [W-1:0] a,
                                             logic [W-1:0] b);
    logic [W-1:0] r;
    case (lat_of(op))
      3:       r = a + b;
      2:       r = a * b;
      default: r = ~a;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  tag, got, exp, cyc);
  endtask

  // one clock cycle: drive at negedge, check, advance the model
  task automatic step(input logic v, input logic [3:0] op,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [TW-1:0] tag, input logic ordy);
    logic         exp_rdy;
    logic         taken;
    logic [W-1:0] fr;
    int           lat;
    int           i;
    in_valid  = v;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
    in_tag    = tag;
    out_ready = ordy;
    if (!rst_n) begin
      pend.delete();
      fifo_q.delete();
    end
    lat   = lat_of(op);
    taken = 1'b0;
    fr    = W'($urandom);
    foreach (pend[k]) begin
      if (pend[k].due == cyc + lat) taken = 1'b1;
      if (pend[k].due == cyc) fr = pend[k].res;
    end
    fpu_result = fr;
    #1;
    exp_rdy = rst_n && !taken && (pend.size() + fifo_q.size() < DEPTH);
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, fifo_q.size() != 0);
    check("busy", busy, pend.size() != 0 || fifo_q.size() != 0);
    check("fpu_a", fpu_a, a);
    if (fifo_q.size() != 0) begin
      check("out_tag", out_tag, fifo_q[0].tag);
      check("out_result", out_result, fifo_q[0].res);
    end else if (!rst_n) begin
      check("rst_out_tag", out_tag, 0);
      check("rst_out_result", out_result, 0);
    end
    obs_ready = in_ready;
    obs_ov    = out_valid;
    obs_busy  = busy;
    obs_tag   = out_tag;
    obs_res   = out_result;
    last_fire = v && exp_rdy;
    if (rst_n) begin
      if (ordy && fifo_q.size() != 0) begin
        popped.push_back(out_tag);
        void'(fifo_q.pop_front());
      end
      i = 0;
      while (i < pend.size()) begin
        if (pend[i].due == cyc) begin
          fifo_q.push_back('{pend[i].tag, pend[i].res});
          pend.delete(i);
        end else i++;
      end
      if (last_fire)
        pend.push_back('{cyc + lat, tag, fpu_model(op, a, b)});
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 4'd0, '0, '0, '0, 1'b1);
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [TW-1:0] tag);
    int n;
    n = 0;
    do begin
      step(1'b1, op, a, b, tag, 1'b1);
      n++;
    end while (!last_fire && n < 20);
    if (!last_fire) check("issue_timeout", 0, 1);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0;
    in_valid = 0; in_a = '0; in_b = '0; in_opcode = '0; in_tag = '0;
    out_ready = 0; fpu_result = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    check("ready_after_reset", obs_ready, 1);

    step(1'b1, 4'd0, 24'd2, 24'd3, 5'd5, 1'b1);
    idle(3);
    check("s1_ov_c3", obs_ov, 0);
    idle(1);
    check("s1_ov_c4", obs_ov, 1);
    check("s1_tag", obs_tag, 5);
    check("s1_res", obs_res, 5);
    idle(1);
    check("s1_busy_c5", obs_busy, 0);

    idle(4);
    step(1'b1, 4'd0, 24'd1, 24'd1, 5'd1, 1'b1);
    step(1'b1, 4'd3, 24'd4, 24'd5, 5'd3, 1'b1);
    check("s2_mul_stall", obs_ready, 0);
    idle(6);

    step(1'b1, 4'd0, 24'd1, 24'd1, 5'd1, 1'b1);
    step(1'b1, 4'd5, 24'd7, 24'd0, 5'd2, 1'b1);
    check("s3_misc_ready", obs_ready, 1);
    idle(2);
    check("s3_tag_c3", obs_tag, 2);
    idle(1);
    check("s3_tag_c4", obs_tag, 1);
    idle(4);

    for (int t = 0; t < 4; t++)
      step(1'b1, 4'd6, W'(t + 100), '0, TW'(10 + t), 1'b0);
    step(1'b1, 4'd6, 24'd9, '0, 5'd14, 1'b0);
    check("s4_full_stall", obs_ready, 0);
    step(1'b1, 4'd6, 24'd9, '0, 5'd14, 1'b1);
    check("s4_pop_cycle", obs_ready, 0);
    step(1'b1, 4'd6, 24'd9, '0, 5'd14, 1'b0);
    check("s4_after_pop", obs_ready, 1);
    idle(8);

    popped.delete();
    for (int t = 0; t < 8; t++)
      issue(4'd0, W'(t), W'(3 * t), TW'(t));
    idle(8);
    check("s5_count", popped.size(), 8);
    for (int t = 0; t < 8 && t < popped.size(); t++)
      check("s5_order", popped[t], t);

    step(1'b1, 4'd0, 24'd6, 24'd6, 5'd7, 1'b1);
    idle(1);
    rst_n = 1'b0;
    idle(1);
    check("s6_busy_rst", obs_busy, 0);
    rst_n = 1'b1;
    idle(1);
    check("s6_ready", obs_ready, 1);
    idle(4);

    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      step($urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)),
           W'($urandom), W'($urandom), TW'($urandom),
           $urandom_range(0, 3) != 0);
    end
    rst_n = 1'b1;
    idle(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
